// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back event into an ASCII trace frame, one character per handshake.
// Optional build macro TRACE_EMITTER_NEWLINE_EN appends 8'h0A after the closing '#'.
module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [15:0] req_time,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_grf,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [7:0]  char,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        frame_done,
  output logic [1:0]  fsm_state
);

  // Handshakes: an event is taken on a rising edge with req_valid && req_ready, and a
  // character moves on a rising edge with char_valid && char_ready; char is held otherwise.
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, EMIT = 2'd2} state_t;

`ifdef TRACE_EMITTER_NEWLINE_EN
  localparam logic [5:0] LAST_SLOT = 6'd38;
`else
  localparam logic [5:0] LAST_SLOT = 6'd37;
`endif

  state_t      state;
  logic [3:0]  conv_cnt;
  logic [5:0]  slot;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        kind_q;
  logic [31:0] pc_q;
  logic [4:0]  grf_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [15:0] bcd_adj;
  logic [1:0]  grf_tens;
  logic [3:0]  grf_ones;
  logic [5:0]  next_slot;
  logic [7:0]  next_char;

  assign fsm_state = state;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    grf_tens = 2'd0;
    grf_ones = grf_q[3:0];
    if (grf_q >= 5'd30) begin
      grf_tens = 2'd3;
      grf_ones = 4'(grf_q - 5'd30);
    end else if (grf_q >= 5'd20) begin
      grf_tens = 2'd2;
      grf_ones = 4'(grf_q - 5'd20);
    end else if (grf_q >= 5'd10) begin
      grf_tens = 2'd1;
      grf_ones = 4'(grf_q - 5'd10);
    end
  end

  // Slots form a fixed layout; insignificant time/grf digit slots are jumped over.
  always_comb begin
    next_slot = slot + 6'd1;
    case (slot)
      6'd0: begin
        if (bcd[15:12] != 4'd0)     next_slot = 6'd1;
        else if (bcd[11:8] != 4'd0) next_slot = 6'd2;
        else if (bcd[7:4] != 4'd0)  next_slot = 6'd3;
        else                        next_slot = 6'd4;
      end
      6'd16: next_slot = (kind_q || grf_tens != 2'd0) ? 6'd17 : 6'd18;
      6'd18: if (!kind_q) next_slot = 6'd25;
      default: ;
    endcase
  end

  always_comb begin
    next_char = 8'h00;
    case (next_slot) inside
      6'd0:            next_char = "^";
      [6'd1:6'd4]:     next_char = 8'h30 + {4'h0, 4'(bcd >> {6'd4 - next_slot, 2'b00})};
      6'd5:            next_char = "@";
      [6'd6:6'd13]:    next_char = hex_char(4'(pc_q >> {6'd13 - next_slot, 2'b00}));
      6'd14:           next_char = ":";
      6'd15:           next_char = " ";
      6'd16:           next_char = kind_q ? "*" : "$";
      [6'd17:6'd24]: begin
        if (kind_q)              next_char = hex_char(4'(addr_q >> {6'd24 - next_slot, 2'b00}));
        else if (next_slot == 6'd17) next_char = 8'h30 + {6'h00, grf_tens};
        else                     next_char = 8'h30 + {4'h0, grf_ones};
      end
      6'd25:           next_char = " ";
      6'd26:           next_char = "<";
      6'd27:           next_char = "=";
      6'd28:           next_char = " ";
      [6'd29:6'd36]:   next_char = hex_char(4'(data_q >> {6'd36 - next_slot, 2'b00}));
      6'd37:           next_char = "#";
      6'd38:           next_char = 8'h0A;
      default:         next_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      char_valid <= 1'b0;
      char       <= 8'h00;
      frame_done <= 1'b0;
      conv_cnt   <= 4'd0;
      slot       <= 6'd0;
      bcd        <= 16'd0;
      bin        <= 14'd0;
      kind_q     <= 1'b0;
      pc_q       <= 32'd0;
      grf_q      <= 5'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            kind_q    <= req_kind;
            pc_q      <= req_pc;
            grf_q     <= req_grf;
            addr_q    <= req_addr;
            data_q    <= req_data;
            bin       <= 14'((req_time > 16'd9999) ? 16'd9999 : req_time);
            bcd       <= 16'd0;
            conv_cnt  <= 4'd0;
            req_ready <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          bcd      <= {bcd_adj[14:0], bin[13]};
          bin      <= {bin[12:0], 1'b0};
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'd13) begin
            conv_cnt   <= 4'd0;
            slot       <= 6'd0;
            char       <= "^";
            char_valid <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (slot == LAST_SLOT) begin
              slot       <= 6'd0;
              char       <= 8'h00;
              char_valid <= 1'b0;
              req_ready  <= 1'b1;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              slot <= next_slot;
              char <= next_char;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Self-checking bench for cpu_trace_emitter: expected frames are rendered with $sformatf into a queue.
module tb_cpu_trace_emitter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_kind;
  logic [15:0] req_time;
  logic [31:0] req_pc;
  logic [4:0]  req_grf;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;
  logic        frame_done;
  logic [1:0]  fsm_state;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_time(req_time), .req_pc(req_pc), .req_grf(req_grf),
    .req_addr(req_addr), .req_data(req_data),
    .char(char), .char_valid(char_valid), .char_ready(char_ready),
    .frame_done(frame_done), .fsm_state(fsm_state)
  );

  task automatic push_frame(input logic k, input logic [15:0] t, input logic [31:0] pc,
                            input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
    string s;
    int tc;
    tc = (t > 16'd9999) ? 9999 : int'(t);
    s = $sformatf("^%0d@%08h: ", tc, pc);
    if (k) s = {s, $sformatf("*%08h", a)};
    else   s = {s, $sformatf("$%0d", g)};
    s = {s, $sformatf(" <= %08h#", d)};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef TRACE_EMITTER_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Entered and left at a falling edge; accept happens on the intervening rising edge.
  task automatic send_event(input logic k, input logic [15:0] t, input logic [31:0] pc,
                            input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_before_accept: got %b expected 1", req_ready);
    else passed++;
    req_valid = 1'b1; req_kind = k; req_time = t; req_pc = pc;
    req_grf = g; req_addr = a; req_data = d;
    push_frame(k, t, pc, g, a, d);
    @(negedge clk);
    req_valid = 1'b0;
    req_kind = 1'($urandom); req_time = 16'($urandom); req_pc = $urandom;
    req_grf = 5'($urandom); req_addr = $urandom; req_data = $urandom;
  endtask

  task automatic wait_first();
    int lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (char_valid === 1'b1) break;
    end
    checks++;
    if (lat !== 14) $display("FAIL first_char_latency: got %0d expected 14", lat);
    else passed++;
  endtask

  // Consumes the expected queue; optionally stalls at one index, or stops after abort_after chars.
  task automatic drain(input int stall_idx, input int stall_len, input int abort_after);
    int idx = 0;
    int stalled = 0;
    int guard = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    while (exp_q.size() > 0 && guard < 2000) begin
      guard++;
      if (abort_after > 0 && idx == abort_after) return;
      if (char_valid !== 1'b1) begin
        char_ready = 1'b1;
        @(negedge clk);
        continue;
      end
      if (idx == stall_idx && stalled < stall_len) begin
        char_ready = 1'b0;
        if (stalled == 0) held = char;
        else begin
          checks++;
          if (char !== held) $display("FAIL char_held_stall: got %h expected %h", char, held);
          else passed++;
        end
        stalled++;
        @(negedge clk);
        continue;
      end
      char_ready = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if (char !== e) $display("FAIL char_%0d: got %h expected %h", idx, char, e);
      else passed++;
      idx++;
      @(negedge clk);
    end
    char_ready = 1'b1;
    checks++;
    if (guard >= 2000) $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    else passed++;
    checks++;
    if (frame_done !== 1'b1 || req_ready !== 1'b1 || char_valid !== 1'b0)
      $display("FAIL frame_end: got done=%b rdy=%b cv=%b expected 1 1 0", frame_done, req_ready, char_valid);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; char_ready = 1'b1;
    req_kind = 1'b0; req_time = 16'd0; req_pc = 32'd0; req_grf = 5'd0;
    req_addr = 32'd0; req_data = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || char_valid !== 1'b0 || char !== 8'h00 || frame_done !== 1'b0 || fsm_state !== 2'd0)
      $display("FAIL reset_values: got rdy=%b cv=%b ch=%h fd=%b st=%0d expected 1 0 00 0 0",
               req_ready, char_valid, char, frame_done, fsm_state);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_register_frame();
    send_event(1'b0, 16'd5, 32'h3000, 5'd3, 32'h0, 32'h12);
    wait_first();
    drain(-1, 0, 0);
  endtask

  task automatic test_memory_frame();
    send_event(1'b1, 16'd1234, 32'h4ffc, 5'd7, 32'h2ffc, 32'hdeadbeef);
    wait_first();
    drain(-1, 0, 0);
  endtask

  task automatic test_backpressure();
    send_event(1'b0, 16'd5, 32'h3000, 5'd3, 32'h0, 32'h12);
    wait_first();
    drain(2, 5, 0);
  endtask

  task automatic test_boundaries();
    send_event(1'b0, 16'd0, 32'h0, 5'd0, 32'h0, 32'h0);
    wait_first();
    drain(-1, 0, 0);
    send_event(1'b0, 16'd40000, 32'hffff_ffff, 5'd31, 32'h0, 32'hffff_ffff);
    wait_first();
    drain(-1, 0, 0);
    send_event(1'b1, 16'd10000, 32'habcd_ef01, 5'd10, 32'h9a8b_7c6d, 32'h0000_000a);
    wait_first();
    drain(-1, 0, 0);
    send_event(1'b0, 16'd65535, 32'h1, 5'd10, 32'h0, 32'h1);
    wait_first();
    drain(-1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      send_event(1'($urandom), 16'($urandom_range(0, 20000)), $urandom,
                 5'($urandom_range(0, 31)), $urandom, $urandom);
      wait_first();
      drain(int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_event(1'b1, 16'd77, 32'h1234_5678, 5'd0, 32'h8765_4321, 32'hcafe_f00d);
    wait_first();
    drain(-1, 0, 10);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (char_valid !== 1'b0 || req_ready !== 1'b1 || frame_done !== 1'b0 || char !== 8'h00)
      $display("FAIL reset_mid_frame: got cv=%b rdy=%b fd=%b ch=%h expected 0 1 0 00",
               char_valid, req_ready, frame_done, char);
    else passed++;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    send_event(1'b0, 16'd42, 32'h3000, 5'd12, 32'h0, 32'h5a5a_a5a5);
    wait_first();
    drain(-1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_register_frame();
    test_memory_frame();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
